// File: rtl/pco_sched_pkg.sv
// pco_sched_pkg: shared run-state encoding and oscillation-cycle constants
package pco_sched_pkg;
    localparam int PW = 4;
    localparam int CYC_LEN = 1 << PW;
    localparam int LAST_SLOT = CYC_LEN - 1;
    typedef enum logic [1:0] {IDLE, SYNC, RUN, DONE} state_e;
endpackage

// File: rtl/pco_rr_arb.sv
// pco_rr_arb: round-robin arbiter, search starts at the pointer and moves past each winner
module pco_rr_arb #(
    parameter int N = 3,
    parameter int PTRW = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [N-1:0]    valid_i,
    input  logic            adv_i,
    output logic [N-1:0]    grant_o,
    output logic [PTRW-1:0] ptr_o
);
    logic [PTRW-1:0] ptr_q, ptr_d, sel;
    int best;

    assign ptr_o = ptr_q;

    // winner is the valid requester at the smallest circular distance from the pointer
    always_comb begin
        grant_o = '0;
        sel = ptr_q;
        best = N;
        for (int i = 0; i < N; i++)
            if (valid_i[i] && (i + N - int'(ptr_q)) % N < best) begin
                best = (i + N - int'(ptr_q)) % N;
                sel = PTRW'(i);
            end
        for (int i = 0; i < N; i++)
            grant_o[i] = best < N && int'(sel) == i;
        ptr_d = adv_i ? ((int'(sel) == N - 1) ? '0 : sel + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) ptr_q <= '0;
        else ptr_q <= ptr_d;
endmodule

// File: rtl/pco_phase_sched.sv
// pco_phase_sched: PCO run controller; phase writes are arbitrated any time
// but only land on phase_out at oscillation-cycle boundaries
module pco_phase_sched #(
    parameter int N_NEUR = 15,
    parameter int N_REQ = 3,
    parameter int PW = 4,
    parameter int IW = 4,
    parameter int STABLE_CYC = 4,
    parameter int CW = 8,
    parameter int MAX_CYC = 200
) (
    input  logic                 clk,
    input  logic                 re_sched_n,
    input  logic                 start,
    input  logic [N_NEUR*PW-1:0] init_phase,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*IW-1:0]  req_idx,
    input  logic [N_REQ*PW-1:0]  req_phase,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 re_pco,
    output logic [N_NEUR*PW-1:0] phase_out,
    output logic                 tick,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CW-1:0]        cyc_cnt
);
    import pco_sched_pkg::*;

    localparam int PTRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e state_q, state_d;
    logic [PW-1:0] slot_q, slot_d;
    logic [CW-1:0] cyc_q, cyc_d, stable_q, stable_d;
    logic timeout_q, timeout_d;
    logic [N_NEUR-1:0][PW-1:0] phase_q, phase_d, pend_q, pend_d;
    logic [N_NEUR-1:0] vld_q, vld_d;
    logic [IW-1:0] wr_idx;
    logic [PW-1:0] wr_phase;
    logic [PTRW-1:0] rr_ptr;
    logic run, changed;

    assign run = state_q == RUN;
    assign tick = run && slot_q == PW'(LAST_SLOT);
    assign re_pco = state_q == IDLE || state_q == SYNC;
    assign busy = state_q == SYNC || run;
    assign done = state_q == DONE;
    assign timeout = timeout_q;
    assign cyc_cnt = cyc_q;
    assign phase_out = phase_q;

    pco_rr_arb #(.N(N_REQ), .PTRW(PTRW)) u_arb (
        .clk_i(clk),
        .rst_n_i(re_sched_n),
        .valid_i(req_valid & {N_REQ{run}}),
        .adv_i(|req_ready),
        .grant_o(req_ready),
        .ptr_o(rr_ptr)
    );

    always_ff @(posedge clk)
        if (re_sched_n) assert (int'(rr_ptr) < N_REQ);

    always_comb begin
        wr_idx = '0;
        wr_phase = '0;
        for (int r = 0; r < N_REQ; r++)
            if (req_ready[r]) begin
                wr_idx = req_idx[r*IW +: IW];
                wr_phase = req_phase[r*PW +: PW];
            end
    end

    always_comb begin
        state_d = state_q;
        slot_d = slot_q;
        cyc_d = cyc_q;
        stable_d = stable_q;
        timeout_d = timeout_q;
        phase_d = phase_q;
        pend_d = pend_q;
        vld_d = (run && !tick) ? vld_q : '0;
        changed = 1'b0;
        for (int i = 0; i < N_NEUR; i++)
            if (tick && vld_q[i]) begin
                changed = changed || pend_q[i] != phase_q[i];
                phase_d[i] = pend_q[i];
            end
        // applied after the commit so a tick-cycle write waits for the next boundary
        if (|req_ready && int'(wr_idx) < N_NEUR) begin
            pend_d[wr_idx] = wr_phase;
            vld_d[wr_idx] = 1'b1;
        end
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = SYNC;
                phase_d = init_phase;
                vld_d = '0;
                cyc_d = '0;
                stable_d = '0;
                timeout_d = 1'b0;
            end
            SYNC: begin
                state_d = RUN;
                slot_d = '0;
            end
            RUN: begin
                slot_d = slot_q + 1'b1;
                if (tick) begin
                    cyc_d = &cyc_q ? cyc_q : cyc_q + 1'b1;
                    stable_d = changed ? '0 : stable_q + 1'b1;
                    if (stable_d >= CW'(STABLE_CYC)) begin
                        state_d = DONE;
                        timeout_d = 1'b0;
                    end else if (cyc_d >= CW'(MAX_CYC)) begin
                        state_d = DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge re_sched_n)
        if (!re_sched_n) begin
            state_q <= IDLE;
            slot_q <= '0;
            cyc_q <= '0;
            stable_q <= '0;
            timeout_q <= 1'b0;
            phase_q <= '0;
            pend_q <= '0;
            vld_q <= '0;
        end else begin
            state_q <= state_d;
            slot_q <= slot_d;
            cyc_q <= cyc_d;
            stable_q <= stable_d;
            timeout_q <= timeout_d;
            phase_q <= phase_d;
            pend_q <= pend_d;
            vld_q <= vld_d;
        end
endmodule

// File: tb/tb_pco_phase_sched.sv
// tb_pco_phase_sched: directed runs plus a per-cycle reference model whose
// expected phase_out is queued each cycle and compared on the next one
module tb_pco_phase_sched;
    localparam int N_NEUR = 15, N_REQ = 3, PW = 4, IW = 4, STABLE_CYC = 4, CW = 8, MAX_CYC = 10;
    localparam int M_IDLE = 0, M_SYNC = 1, M_RUN = 2, M_DONE = 3;

    logic clk, re_sched_n, start;
    logic [N_NEUR*PW-1:0] init_phase, phase_out;
    logic [N_REQ-1:0] req_valid, req_ready;
    logic [N_REQ*IW-1:0] req_idx;
    logic [N_REQ*PW-1:0] req_phase;
    logic re_pco, tick, busy, done, timeout;
    logic [CW-1:0] cyc_cnt;

    int total = 0, bad = 0;

    pco_phase_sched #(
        .N_NEUR(N_NEUR), .N_REQ(N_REQ), .PW(PW), .IW(IW),
        .STABLE_CYC(STABLE_CYC), .CW(CW), .MAX_CYC(MAX_CYC)
    ) dut (
        .clk(clk), .re_sched_n(re_sched_n), .start(start), .init_phase(init_phase),
        .req_valid(req_valid), .req_idx(req_idx), .req_phase(req_phase),
        .req_ready(req_ready), .re_pco(re_pco), .phase_out(phase_out),
        .tick(tick), .busy(busy), .done(done), .timeout(timeout), .cyc_cnt(cyc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // reference model state
    int mm = M_IDLE, mptr = 0;
    logic [3:0] ms = '0;
    logic [7:0] mcyc = '0, mst = '0;
    logic mto = 1'b0;
    logic [N_NEUR-1:0][PW-1:0] mph = '0, mpend = '0;
    logic [N_NEUR-1:0] mvld = '0;
    logic [N_NEUR*PW-1:0] sb[$];

    always @(negedge clk) begin
        logic [N_REQ-1:0] eg;
        logic chg;
        int g, ix;
        if (!re_sched_n) begin
            mm = M_IDLE; ms = '0; mcyc = '0; mst = '0; mto = 1'b0;
            mph = '0; mvld = '0; mptr = 0;
            sb.delete();
        end else begin
            eg = '0;
            g = -1;
            if (mm == M_RUN)
                for (int k = 0; k < N_REQ; k++)
                    if (g < 0 && req_valid[(mptr + k) % N_REQ]) g = (mptr + k) % N_REQ;
            if (g >= 0) eg[g] = 1'b1;
            if (sb.size() > 0) check("phase_out", phase_out, sb.pop_front());
            check("req_ready", req_ready, eg);
            check("tick", tick, mm == M_RUN && ms == 4'd15);
            check("re_pco", re_pco, mm <= M_SYNC);
            check("busy", busy, mm == M_SYNC || mm == M_RUN);
            check("done", done, mm == M_DONE);
            check("timeout", timeout, mto);
            check("cyc_cnt", cyc_cnt, mcyc);
            case (mm)
                M_IDLE, M_DONE: if (start) begin
                    mph = init_phase; mvld = '0; mcyc = '0; mst = '0; mto = 1'b0; mm = M_SYNC;
                end
                M_SYNC: begin
                    ms = '0;
                    mm = M_RUN;
                end
                M_RUN: begin
                    if (ms == 4'd15) begin
                        chg = 1'b0;
                        for (int i = 0; i < N_NEUR; i++)
                            if (mvld[i]) begin
                                if (mph[i] != mpend[i]) chg = 1'b1;
                                mph[i] = mpend[i];
                            end
                        mvld = '0;
                        if (mcyc != 8'hFF) mcyc = mcyc + 1;
                        mst = chg ? 8'd0 : mst + 1;
                        if (mst >= STABLE_CYC) begin mm = M_DONE; mto = 1'b0; end
                        else if (mcyc >= MAX_CYC) begin mm = M_DONE; mto = 1'b1; end
                    end
                    ms = ms + 1;
                    if (g >= 0) begin
                        mptr = (g + 1) % N_REQ;
                        ix = int'(req_idx[g*IW +: IW]);
                        if (ix < N_NEUR) begin
                            mpend[ix] = req_phase[g*PW +: PW];
                            mvld[ix] = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            sb.push_back(mph);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_start(input logic [N_NEUR*PW-1:0] init);
        init_phase = init;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 400) begin
            step();
            n++;
        end
        check("done_reached", done, 1'b1);
    endtask

    task automatic burst(input logic [N_REQ*IW-1:0] ix, input logic [N_REQ*PW-1:0] ph);
        req_idx = ix;
        req_phase = ph;
        req_valid = '1;
        for (int r = 0; r < N_REQ; r++) begin
            #1;
            check("burst_grant", req_ready, 3'(1) << r);
            step();
            req_valid[r] = 1'b0;
        end
    endtask

    initial begin
        logic [N_NEUR*PW-1:0] e;
        int n;
        re_sched_n = 1'b1; start = 1'b0; init_phase = '0;
        req_valid = '0; req_idx = '0; req_phase = '0;
        #1 re_sched_n = 1'b0;
        #2;
        check("rst_re_pco", re_pco, 1'b1);
        check("rst_phase", phase_out, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tick", tick, 1'b0);
        check("rst_ready", req_ready, '0);
        check("rst_cyc", cyc_cnt, '0);
        steps(2);
        re_sched_n = 1'b1;
        step();

        // idle run: DONE after SYNC plus 64 RUN clocks
        do_start('0);
        check("sync_re_pco", re_pco, 1'b1);
        wait_done(n);
        check("idle_latency", n, 65);
        check("idle_cyc", cyc_cnt, 4);
        check("idle_timeout", timeout, 1'b0);

        // three simultaneous requesters served in rotation
        do_start('0);
        steps(3);
        burst({4'd2, 4'd1, 4'd0}, {4'd7, 4'd5, 4'd3});
        wait_done(n);
        e = '0; e[3:0] = 4'd3; e[7:4] = 4'd5; e[11:8] = 4'd7;
        check("rr_phase", phase_out, e);
        check("rr_cyc", cyc_cnt, 5);
        check("rr_timeout", timeout, 1'b0);

        // same index twice (last wins) and an out-of-range index
        do_start('0);
        steps(3);
        burst({4'd15, 4'd6, 4'd6}, {4'hA, 4'd9, 4'd4});
        wait_done(n);
        e = '0; e[27:24] = 4'd9;
        check("ovw_phase", phase_out, e);
        check("ovw_cyc", cyc_cnt, 5);

        // write granted in the tick cycle lands one boundary later
        do_start('0);
        steps(16);
        req_valid = 3'b001; req_idx = {3{4'd3}}; req_phase = {3{4'hC}};
        #1;
        check("tw_tick", tick, 1'b1);
        check("tw_grant", req_ready, 3'b001);
        step();
        req_valid = '0;
        check("tw_hold0", phase_out, '0);
        steps(15);
        check("tw_hold1", phase_out, '0);
        step();
        e = '0; e[15:12] = 4'hC;
        check("tw_commit", phase_out, e);
        wait_done(n);
        check("tw_cyc", cyc_cnt, 6);

        // rewriting the current value keeps the stability count running
        e = '0; e[3:0] = 4'd5;
        do_start(e);
        steps(3);
        req_valid = 3'b001; req_idx = '0; req_phase = {3{4'd5}};
        #1;
        check("same_grant", req_ready, 3'b001);
        step();
        req_valid = '0;
        wait_done(n);
        check("same_phase", phase_out, e);
        check("same_cyc", cyc_cnt, 4);

        // toggling neuron 0 every cycle never stabilises
        do_start('0);
        steps(3);
        for (int c = 0; c < 10; c++) begin
            req_valid = 3'b001; req_idx = '0; req_phase = {3{4'(c % 2 + 1)}};
            step();
            req_valid = '0;
            if (c < 9) steps(15);
        end
        wait_done(n);
        check("to_timeout", timeout, 1'b1);
        check("to_cyc", cyc_cnt, 10);
        check("to_phase0", phase_out[3:0], 4'd2);

        // asynchronous reset mid-run, then a clean run
        do_start(60'hFEDCBA987654321);
        steps(8);
        #2 re_sched_n = 1'b0;
        #1;
        check("ar_re_pco", re_pco, 1'b1);
        check("ar_phase", phase_out, '0);
        check("ar_busy", busy, 1'b0);
        check("ar_tick", tick, 1'b0);
        steps(2);
        re_sched_n = 1'b1;
        step();
        do_start(60'h123456789ABCDEF);
        wait_done(n);
        check("post_phase", phase_out, 60'h123456789ABCDEF);
        check("post_cyc", cyc_cnt, 4);
        check("post_timeout", timeout, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end
endmodule
